shift_add_multiplier: RTL and testbench

// - Iterative radix-2 multiplier for LEGv8 MUL/SMULH/UMULH; sits in EX beside the ALU.
// - Consumes the existing `adder` (sub=0) as its accumulate stage, one add per cycle.
// - Produces the full 2*DATA_WIDTH-bit product: MUL takes product_lo, xMULH takes product_hi.
// - Start/ready/done handshake; the pipeline stalls on !ready.

---
 rtl/shift_add_multiplier.sv | 142 ++++++++++++++
 tb/tb_shift_add_multiplier.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_add_multiplier.sv
// Iterative radix-2 shift-add multiplier (LEGv8 MUL/SMULH/UMULH).
// Signed operands are multiplied as magnitudes, and the 2W-bit result is negated at the end.

module adder #(
  parameter int W = 64
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic [W-1:0] sum,
  output logic         carry_out,
  output logic         overflow
);
  logic [W-1:0] b_eff;
  logic [W:0]   full;

  always_comb begin
    b_eff     = sub ? ~b : b;
    full      = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, sub};
    sum       = full[W-1:0];
    carry_out = full[W];
    overflow  = (a[W-1] == b_eff[W-1]) && (sum[W-1] != a[W-1]);
  end
endmodule

module shift_add_multiplier #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  is_signed,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  ready,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] product_lo,
  output logic [DATA_WIDTH-1:0] product_hi
);
  localparam int W  = DATA_WIDTH;
  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   mag_a_q, mag_a_d;
  logic [W-1:0]   acc_hi_q, acc_hi_d;
  logic [W-1:0]   acc_lo_q, acc_lo_d;
  logic           neg_q, neg_d;
  logic [CW-1:0]  count_q, count_d;
  logic [W-1:0]   prod_lo_q, prod_lo_d;
  logic [W-1:0]   prod_hi_q, prod_hi_d;

  logic [W-1:0]   addend;
  logic [W-1:0]   add_sum;
  logic           add_cout;
  logic           unused_ovf;
  logic [2*W-1:0] shifted;
  logic [2*W-1:0] final_p;

  assign addend = acc_lo_q[0] ? mag_a_q : '0;

  adder #(.W(W)) u_adder (
    .a         (acc_hi_q),
    .b         (addend),
    .sub       (1'b0),
    .sum       (add_sum),
    .carry_out (add_cout),
    .overflow  (unused_ovf)
  );

  // The adder carry becomes the top bit of the accumulator after the right shift.
  assign shifted = {add_cout, add_sum, acc_lo_q[W-1:1]};
  assign final_p = neg_q ? (~shifted) + {{(2*W-1){1'b0}}, 1'b1} : shifted;

  always_comb begin
    state_d   = state_q;
    mag_a_d   = mag_a_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    neg_d     = neg_q;
    count_d   = count_q;
    prod_lo_d = prod_lo_q;
    prod_hi_d = prod_hi_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // |most-negative| still fits as an unsigned W-bit magnitude.
          mag_a_d  = (is_signed && A[W-1]) ? (~A) + {{(W-1){1'b0}}, 1'b1} : A;
          acc_lo_d = (is_signed && B[W-1]) ? (~B) + {{(W-1){1'b0}}, 1'b1} : B;
          acc_hi_d = '0;
          neg_d    = is_signed & (A[W-1] ^ B[W-1]);
          count_d  = '0;
          state_d  = S_ITER;
        end
      end
      S_ITER: begin
        acc_hi_d = shifted[2*W-1:W];
        acc_lo_d = shifted[W-1:0];
        count_d  = count_q + 1'b1;
        if (count_q == CW'(W-1)) begin
          prod_hi_d = final_p[2*W-1:W];
          prod_lo_d = final_p[W-1:0];
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      mag_a_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      neg_q     <= 1'b0;
      count_q   <= '0;
      prod_lo_q <= '0;
      prod_hi_q <= '0;
    end else begin
      state_q   <= state_d;
      mag_a_q   <= mag_a_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      neg_q     <= neg_d;
      count_q   <= count_d;
      prod_lo_q <= prod_lo_d;
      prod_hi_q <= prod_hi_d;
    end
  end

  assign ready      = (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);
  assign product_lo = prod_lo_q;
  assign product_hi = prod_hi_q;
endmodule

// File: tb/tb_shift_add_multiplier.sv
// Scoreboard bench for shift_add_multiplier: expected products queued at start,
// popped and compared by a monitor on every done pulse.

module tb_shift_add_multiplier;
  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset, start, is_signed;
  logic [W-1:0] A, B;
  logic         ready, done;
  logic [W-1:0] product_lo, product_hi;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t   sb_q[$];
  exp_t   mon_e;
  int     n_cmp = 0, n_err = 0, n_start = 0, n_done = 0;
  longint cyc = 0, start_cyc = 0;
  logic   done_prev = 1'b0;

  shift_add_multiplier #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_signed  (is_signed),
    .A          (A),
    .B          (B),
    .ready      (ready),
    .done       (done),
    .product_lo (product_lo),
    .product_hi (product_hi)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      n_done++;
      n_cmp++;
      if (done_prev) begin
        n_err++;
        $display("FAIL done_width: done high for two cycles at cyc %0d", cyc);
      end
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done: got hi=%h lo=%h with empty scoreboard", product_hi, product_lo);
      end else begin
        mon_e = sb_q.pop_front();
        if (product_hi !== mon_e.hi || product_lo !== mon_e.lo) begin
          n_err++;
          $display("FAIL product: got hi=%h lo=%h want hi=%h lo=%h", product_hi, product_lo, mon_e.hi, mon_e.lo);
        end
      end
    end
    done_prev = done;
  end

  function automatic exp_t golden(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic signed [2*W-1:0] sa, sb2, p;
    if (s) begin
      sa  = {{W{a[W-1]}}, a};
      sb2 = {{W{b[W-1]}}, b};
      p   = sa * sb2;
    end else begin
      p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end
    return p;
  endfunction

  function automatic logic [W-1:0] pick();
    logic [W-1:0] v;
    case ($urandom_range(0, 7))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = 64'd1;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  // Waits for ready, presents an operation for one sampling edge; optionally keeps start high.
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input exp_t e, input bit push_it, input bit keep);
    int t = 0;
    @(negedge clk);
    while (!ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL issue_timeout: ready=%b want 1", ready);
    end
    A = a; B = b; is_signed = s; start = 1'b1;
    if (push_it) begin
      sb_q.push_back(e);
      n_start++;
    end
    @(negedge clk);
    start_cyc = cyc;
    if (!keep) start = 1'b0;
    A = {$urandom, $urandom};
    B = {$urandom, $urandom};
    is_signed = ~s;
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: done=%b want 1 within 300 cycles", done);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; is_signed = 1'b0; A = '0; B = '0;
    repeat (2) @(negedge clk);
    n_cmp += 4;
    if (ready !== 1'b1)  begin n_err++; $display("FAIL reset_ready: got %b want 1", ready); end
    if (done !== 1'b0)   begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    if (product_lo !== '0) begin n_err++; $display("FAIL reset_lo: got %h want 0", product_lo); end
    if (product_hi !== '0) begin n_err++; $display("FAIL reset_hi: got %h want 0", product_hi); end
    reset = 1'b0;
  endtask

  task automatic test_unsigned_max();
    bit ok;
    exp_t e;
    e.hi = 64'hFFFF_FFFF_FFFF_FFFE;
    e.lo = 64'h1;
    issue('1, '1, 1'b0, e, 1'b1, 1'b0);
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL busy_ready: got %b want 0", ready); end
    wait_done(ok);
    if (ok) begin
      n_cmp += 2;
      if (cyc - start_cyc != 64) begin
        n_err++;
        $display("FAIL latency: got %0d edges want 64", cyc - start_cyc);
      end
      if (ready !== 1'b0) begin n_err++; $display("FAIL done_ready: got %b want 0", ready); end
    end
    repeat (3) @(negedge clk);
    n_cmp += 2;
    if (product_hi !== e.hi || product_lo !== e.lo) begin
      n_err++;
      $display("FAIL hold: got hi=%h lo=%h want hi=%h lo=%h", product_hi, product_lo, e.hi, e.lo);
    end
    if (ready !== 1'b1) begin n_err++; $display("FAIL idle_ready: got %b want 1", ready); end
  endtask

  task automatic test_signed_small();
    bit ok;
    exp_t e;
    e.hi = '1; e.lo = 64'hFFFF_FFFF_FFFF_FFFD;
    issue('1, 64'd3, 1'b1, e, 1'b1, 1'b0);
    wait_done(ok);
    e.hi = 64'd2; e.lo = 64'hFFFF_FFFF_FFFF_FFFD;
    issue('1, 64'd3, 1'b0, e, 1'b1, 1'b0);
    wait_done(ok);
  endtask

  task automatic test_min_neg();
    bit ok;
    exp_t e;
    e.hi = 64'h4000_0000_0000_0000; e.lo = '0;
    issue(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, e, 1'b1, 1'b0);
    wait_done(ok);
    e.hi = '1; e.lo = 64'h8000_0000_0000_0000;
    issue(64'h8000_0000_0000_0000, 64'd1, 1'b1, e, 1'b1, 1'b0);
    wait_done(ok);
    e.hi = '0; e.lo = '0;
    issue('0, 64'hFFFF_FFFF_FFFF_FFFB, 1'b1, e, 1'b1, 1'b0);
    wait_done(ok);
  endtask

  task automatic test_back_to_back();
    bit ok;
    int t = 0;
    logic [W-1:0] a1 = 64'h0123_4567_89AB_CDEF, b1 = 64'hFEDC_BA98_7654_3210;
    logic [W-1:0] a2 = 64'hDEAD_BEEF_0000_0011, b2 = 64'h0000_0000_CAFE_F00D;
    issue(a1, b1, 1'b0, golden(a1, b1, 1'b0), 1'b1, 1'b1);
    while (!ready && t < 200) begin
      A = {$urandom, $urandom};
      B = {$urandom, $urandom};
      is_signed = $urandom_range(0, 1);
      @(negedge clk);
      t++;
    end
    A = a2; B = b2; is_signed = 1'b1;
    sb_q.push_back(golden(a2, b2, 1'b1));
    n_start++;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (ready !== 1'b0) begin n_err++; $display("FAIL b2b_accept: ready=%b want 0", ready); end
    wait_done(ok);
  endtask

  task automatic test_reset_mid_iter();
    bit ok;
    exp_t e;
    e.hi = '0; e.lo = '0;
    issue(64'd100, 64'd200, 1'b0, e, 1'b0, 1'b0);
    repeat (30) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp += 4;
    if (ready !== 1'b1)    begin n_err++; $display("FAIL mid_reset_ready: got %b want 1", ready); end
    if (done !== 1'b0)     begin n_err++; $display("FAIL mid_reset_done: got %b want 0", done); end
    if (product_lo !== '0) begin n_err++; $display("FAIL mid_reset_lo: got %h want 0", product_lo); end
    if (product_hi !== '0) begin n_err++; $display("FAIL mid_reset_hi: got %h want 0", product_hi); end
    @(negedge clk);
    reset = 1'b0;
    repeat (80) @(negedge clk);
    e.hi = '0; e.lo = 64'd63;
    issue(64'd7, 64'd9, 1'b0, e, 1'b1, 1'b0);
    wait_done(ok);
  endtask

  task automatic test_random(input int n);
    bit ok;
    logic [W-1:0] a, b;
    logic s;
    for (int i = 0; i < n; i++) begin
      a = pick();
      b = pick();
      s = $urandom_range(0, 1);
      issue(a, b, s, golden(a, b, s), 1'b1, 1'b0);
      wait_done(ok);
      if (!ok) break;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned_max();
    test_signed_small();
    test_min_neg();
    test_back_to_back();
    test_reset_mid_iter();
    test_random(1000);
    repeat (3) @(negedge clk);
    n_cmp += 2;
    if (n_done != n_start) begin
      n_err++;
      $display("FAIL done_count: got %0d pulses want %0d", n_done, n_start);
    end
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_left: got %0d pending want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
